// File: rtl/doomsoc_pll_pkg.sv
// rtl/doomsoc_pll_pkg.sv - shared state encoding and counter sizing for the PLL reset sequencer
package doomsoc_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_t;

    // Bits needed by a counter that runs 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL kick, lock qualification and staged reset release
module pll_reset_seq
    import doomsoc_pll_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [2:0]            state
);

    localparam int REL_SPAN = (NUM_STAGES > 1) ? (NUM_STAGES - 1) * STAGE_GAP : 1;
    localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD   = (LOCK_STABLE_CYCLES > REL_SPAN) ? LOCK_STABLE_CYCLES : REL_SPAN;
    localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(REL_SPAN - 1);

    pll_state_t       st;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st              <= PLL_RESET;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            rst_out         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else if ((st == RELEASE || st == RUN) && !lock_s) begin
            // Lock lost after release began: clamp every stage and re-kick the PLL.
            st      <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            if (lock_loss_count != '1)
                lock_loss_count <= lock_loss_count + 1'b1;
        end else begin
            case (st)
                PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        st      <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= STABLE;
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        st      <= PLL_RESET;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        st  <= WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        cnt        <= '0;
                        rst_out[0] <= 1'b0;
                        if (NUM_STAGES == 1) begin
                            st    <= RUN;
                            ready <= 1'b1;
                        end else begin
                            st <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    cnt <= cnt + 1'b1;
                    // Stage k must read 0 in the cycle where cnt == k*STAGE_GAP.
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        if (cnt == CNT_W'(k * STAGE_GAP - 1))
                            rst_out[k] <= 1'b0;
                    end
                    if (cnt == REL_LAST) begin
                        st    <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready   <= 1'b1;
                    rst_out <= '0;
                end
                default: begin
                    st      <= PLL_RESET;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed bench for pll_reset_seq with shortened timing parameters
module tb_pll_reset_seq;

    localparam int LSC = 32;
    localparam int GAP = 4;
    localparam int NS  = 3;
    localparam int TO  = 64;
    localparam int PRC = 8;
    localparam int LW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [LW-1:0] lock_loss_count;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP          (GAP),
        .NUM_STAGES         (NS),
        .LOCK_TIMEOUT       (TO),
        .PLL_RST_CYCLES     (PRC),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .rst_out         (rst_out),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        int n = 0;
        while (state !== s && n < lim) begin
            tick(1);
            n++;
        end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    // Holds rst for a few edges, then drops it; afterwards we sit at "0 edges since release".
    task automatic do_reset(input logic lk);
        pll_locked = lk;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        pll_locked = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("rst_state",   {29'd0, state}, 32'd0);
        chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("rst_rst_out", {29'd0, rst_out}, 32'd7);
        chk("rst_ready",   {31'd0, ready}, 32'd0);
        chk("rst_count",   {28'd0, lock_loss_count}, 32'd0);
        rst = 1'b0;

        // Normal bring-up: lock at 20, STABLE at 23, RELEASE at 55, RUN at 63
        tick(7);
        chk("up_pll_rst_hi7", {31'd0, pll_rst}, 32'd1);
        tick(1);
        chk("up_pll_rst_lo8", {31'd0, pll_rst}, 32'd0);
        chk("up_wait_lock",   {29'd0, state}, 32'd1);
        tick(12);
        pll_locked = 1'b1;
        tick(2);
        chk("up_still_wait",  {29'd0, state}, 32'd1);
        tick(1);
        chk("up_stable",      {29'd0, state}, 32'd2);
        tick(31);
        chk("up_pre_rel_st",  {29'd0, state}, 32'd2);
        chk("up_pre_rel_out", {29'd0, rst_out}, 32'd7);
        tick(1);
        chk("up_rel_st",      {29'd0, state}, 32'd3);
        chk("up_rel_out0",    {29'd0, rst_out}, 32'd6);
        chk("up_rel_ready",   {31'd0, ready}, 32'd0);
        tick(3);
        chk("up_pre_stage1",  {29'd0, rst_out}, 32'd6);
        tick(1);
        chk("up_stage1",      {29'd0, rst_out}, 32'd4);
        tick(3);
        chk("up_pre_stage2",  {29'd0, rst_out}, 32'd4);
        chk("up_pre_ready",   {31'd0, ready}, 32'd0);
        tick(1);
        chk("up_stage2",      {29'd0, rst_out}, 32'd0);
        chk("up_ready",       {31'd0, ready}, 32'd1);
        chk("up_run",         {29'd0, state}, 32'd4);

        // Lock loss in RUN: pin drops after edge 70, reaction visible after edge 73
        tick(7);
        chk("run_ready_hold", {31'd0, ready}, 32'd1);
        pll_locked = 1'b0;
        tick(2);
        chk("loss_ready_pre", {31'd0, ready}, 32'd1);
        chk("loss_cnt_pre",   {28'd0, lock_loss_count}, 32'd0);
        tick(1);
        chk("loss_ready",     {31'd0, ready}, 32'd0);
        chk("loss_rst_out",   {29'd0, rst_out}, 32'd7);
        chk("loss_cnt",       {28'd0, lock_loss_count}, 32'd1);
        chk("loss_state",     {29'd0, state}, 32'd0);
        chk("loss_pll_rst",   {31'd0, pll_rst}, 32'd1);
        tick(7);
        chk("loss_pulse_end", {31'd0, pll_rst}, 32'd1);
        tick(1);
        chk("loss_pulse_off", {31'd0, pll_rst}, 32'd0);

        // Flaky lock: high at 20, low at 40 (seen at 43), high again at 43 -> STABLE 46, RELEASE 78
        do_reset(1'b0);
        tick(20);
        pll_locked = 1'b1;
        tick(20);
        pll_locked = 1'b0;
        tick(2);
        chk("flaky_still_stable", {29'd0, state}, 32'd2);
        tick(1);
        chk("flaky_back_wait",    {29'd0, state}, 32'd1);
        pll_locked = 1'b1;
        tick(3);
        chk("flaky_restable",     {29'd0, state}, 32'd2);
        tick(10);
        chk("flaky_no_early_rel", {29'd0, rst_out}, 32'd7);
        tick(21);
        chk("flaky_pre_rel",      {29'd0, rst_out}, 32'd7);
        tick(1);
        chk("flaky_rel",          {29'd0, rst_out}, 32'd6);
        chk("flaky_rel_state",    {29'd0, state}, 32'd3);

        // Timeout: no lock -> WAIT_LOCK 8..71, re-kick at 72 and 144
        do_reset(1'b0);
        tick(71);
        chk("to_wait_end",    {31'd0, pll_rst}, 32'd0);
        chk("to_wait_state",  {29'd0, state}, 32'd1);
        tick(1);
        chk("to_rekick",      {31'd0, pll_rst}, 32'd1);
        chk("to_rekick_st",   {29'd0, state}, 32'd0);
        tick(8);
        chk("to_pulse_off",   {31'd0, pll_rst}, 32'd0);
        tick(63);
        chk("to_pre_rekick2", {31'd0, pll_rst}, 32'd0);
        tick(1);
        chk("to_rekick2",     {31'd0, pll_rst}, 32'd1);
        chk("to_rst_out",     {29'd0, rst_out}, 32'd7);
        chk("to_ready",       {31'd0, ready}, 32'd0);

        // Saturation: 20 losses during RELEASE, counter must stop at 15
        do_reset(1'b0);
        for (int i = 1; i <= 20; i++) begin
            pll_locked = 1'b1;
            wait_state(3'd3, 200, "sat_reach_release");
            pll_locked = 1'b0;
            wait_state(3'd0, 10, "sat_reach_pll_reset");
            chk($sformatf("sat_count_%0d", i), {28'd0, lock_loss_count},
                (i < 15) ? i : 15);
        end

        // rst asserted in RUN aborts on the next edge, then a full pulse follows
        pll_locked = 1'b1;
        wait_state(3'd4, 200, "rr_reach_run");
        chk("rr_ready_run", {31'd0, ready}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk("rr_state",   {29'd0, state}, 32'd0);
        chk("rr_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("rr_rst_out", {29'd0, rst_out}, 32'd7);
        chk("rr_ready",   {31'd0, ready}, 32'd0);
        chk("rr_count",   {28'd0, lock_loss_count}, 32'd0);
        rst = 1'b0;
        tick(7);
        chk("rr_pulse_hi7", {31'd0, pll_rst}, 32'd1);
        chk("rr_pulse_st7", {29'd0, state}, 32'd0);
        tick(1);
        chk("rr_pulse_lo8", {31'd0, pll_rst}, 32'd0);
        chk("rr_wait",      {29'd0, state}, 32'd1);
        tick(1);
        chk("rr_stable",    {29'd0, state}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
